vc_buffer: RTL and testbench

Multi-channel input buffer for the dynamic router input port: NUM_VC independent show-ahead FIFOs share one storage array, each with its own head/tail pointers, occupancy count and flags. It extends the single-channel flit buffer with:
- virtual-channel selection on both ports
- non-power-of-two depth
- per-VC occupancy
- credit return to the upstream router
- sticky overflow detection

It sits between the link receiver and the VC allocator/crossbar.

---
 rtl/buffer_pkg.sv | 42 ++++
 rtl/vc_fifo_ctrl.sv | 79 +++++++
 rtl/vc_buffer.sv | 170 +++++++++++++++++
 tb/tb_vc_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// buffer_pkg: shared helpers and types for the multi-VC router input buffer.
//   clog2       - ceiling log2 constant function
//   vc_width    - width of a VC index, at least one bit
//   cnt_width   - width of an occupancy count that can hold 0..depth
//   ptr_width   - width of a head/tail pointer, at least one bit
//   credit_t    - credit pulse to the upstream router (valid, vc)
package buffer_pkg;

    // Widest VC index the credit record can carry; users slice down to VC_W.
    localparam int CREDIT_VC_MAX_W = 8;

    function automatic int clog2(input int value);
        int result;
        int one;
        result = 0;
        one    = 1;
        for (int i = 0; i < 31; i++) begin
            if ((one << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int vc_width(input int num_vc);
        return (num_vc <= 1) ? 1 : clog2(num_vc);
    endfunction

    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : clog2(depth);
    endfunction

    typedef struct packed {
        logic                       valid;
        logic [CREDIT_VC_MAX_W-1:0] vc;
    } credit_t;

endpackage

// File: rtl/vc_fifo_ctrl.sv
// vc_fifo_ctrl: pointer/count bookkeeping for one virtual channel.
//   clk, rst          - clock, asynchronous active-high reset
//   wr_req, rd_req    - write / read requests already decoded for this VC
//   wr_ok, rd_ok      - request accepted this cycle (from pre-edge full/empty)
//   head, tail        - read and write slot within this VC's region
//   count, count_nxt  - current occupancy and occupancy after this edge
//   empty, full       - registered flags derived from the count
//   overflow          - sticky: a write was attempted while full
module vc_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             wr_ok,
    output logic             rd_ok,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_r;
    logic             full_r;
    logic             overflow_r;

    // Accept decisions and next occupancy; a full VC takes only the read, an empty VC only the write.
    always_comb begin
        wr_ok = wr_req && !full_r;
        rd_ok = rd_req && !empty_r;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count_r + CNT_W'(1);
            2'b01:   count_nxt = count_r - CNT_W'(1);
            default: count_nxt = count_r;
        endcase
    end

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work; flags follow the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (rd_ok) begin
                head_r <= (head_r == PTR_W'(DEPTH - 1)) ? '0 : head_r + PTR_W'(1);
            end
            if (wr_ok) begin
                tail_r <= (tail_r == PTR_W'(DEPTH - 1)) ? '0 : tail_r + PTR_W'(1);
            end
            if (wr_req && full_r) begin
                overflow_r <= 1'b1;
            end
            count_r <= count_nxt;
            empty_r <= (count_nxt == CNT_W'(0));
            full_r  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    assign head     = head_r;
    assign tail     = tail_r;
    assign count    = count_r;
    assign empty    = empty_r;
    assign full     = full_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/vc_buffer.sv
// vc_buffer: NUM_VC show-ahead FIFOs sharing one storage array, with credit
// return to the upstream router and sticky per-VC overflow flags.
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid/in_vc/in_data   - write port
//   out_req/out_vc/out_data  - dequeue request and combinational head flit of out_vc
//   empty, full, usedw       - per-VC flags and occupancy (VC0 in LSBs)
//   credit_valid, credit_vc  - one-cycle credit pulse after each accepted read
//   overflow                 - sticky per-VC write-while-full flag
//   peak_usedw               - per-VC high-water mark
// Build option: define VC_BUFFER_STATS_EN to enable high-water tracking and a
// periodic simulation-only occupancy print; otherwise peak_usedw reads zero.
module vc_buffer
    import buffer_pkg::*;
#(
    parameter  int BUFFER_DEPTH = 8,
    parameter  int BUFFER_WIDTH = 64,
    parameter  int NUM_VC       = 2,
    localparam int VC_W         = vc_width(NUM_VC),
    localparam int CNT_W        = cnt_width(BUFFER_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [VC_W-1:0]         in_vc,
    input  logic [BUFFER_WIDTH-1:0] in_data,
    input  logic                    out_req,
    input  logic [VC_W-1:0]         out_vc,
    output logic [BUFFER_WIDTH-1:0] out_data,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC*CNT_W-1:0] usedw,
    output logic                    credit_valid,
    output logic [VC_W-1:0]         credit_vc,
    output logic [NUM_VC-1:0]       overflow,
    output logic [NUM_VC*CNT_W-1:0] peak_usedw
);

    localparam int PTR_W  = ptr_width(BUFFER_DEPTH);
    localparam int ADDR_W = ptr_width(NUM_VC * BUFFER_DEPTH);

    logic [BUFFER_WIDTH-1:0]            mem_r [NUM_VC*BUFFER_DEPTH];
    logic [NUM_VC-1:0]                  wr_req_s;
    logic [NUM_VC-1:0]                  rd_req_s;
    logic [NUM_VC-1:0]                  wr_ok_s;
    logic [NUM_VC-1:0]                  rd_ok_s;
    logic [NUM_VC-1:0][PTR_W-1:0]       head_s;
    logic [NUM_VC-1:0][PTR_W-1:0]       tail_s;
    logic [NUM_VC-1:0][CNT_W-1:0]       count_s;
    logic [NUM_VC-1:0][CNT_W-1:0]       count_nxt_s;
    logic                               in_vc_ok_s;
    logic                               out_vc_ok_s;
    logic [ADDR_W-1:0]                  wr_addr_s;
    logic [ADDR_W-1:0]                  rd_addr_s;
    credit_t                            credit_r;

    // Decode requests per VC; an out-of-range VC index raises no request at all.
    always_comb begin
        in_vc_ok_s  = (int'(in_vc) < NUM_VC);
        out_vc_ok_s = (int'(out_vc) < NUM_VC);
        for (int v = 0; v < NUM_VC; v++) begin
            wr_req_s[v] = in_valid && in_vc_ok_s && (int'(in_vc) == v);
            rd_req_s[v] = out_req && out_vc_ok_s && (int'(out_vc) == v);
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo_ctrl #(
            .DEPTH (BUFFER_DEPTH),
            .CNT_W (CNT_W),
            .PTR_W (PTR_W)
        ) u_ctrl (
            .clk       (clk),
            .rst       (rst),
            .wr_req    (wr_req_s[v]),
            .rd_req    (rd_req_s[v]),
            .wr_ok     (wr_ok_s[v]),
            .rd_ok     (rd_ok_s[v]),
            .head      (head_s[v]),
            .tail      (tail_s[v]),
            .count     (count_s[v]),
            .count_nxt (count_nxt_s[v]),
            .empty     (empty[v]),
            .full      (full[v]),
            .overflow  (overflow[v])
        );
    end

    // Each VC owns a contiguous BUFFER_DEPTH-word region of the shared array.
    always_comb begin
        if (in_vc_ok_s) begin
            wr_addr_s = ADDR_W'(int'(in_vc) * BUFFER_DEPTH + int'(tail_s[in_vc]));
        end else begin
            wr_addr_s = '0;
        end
        if (out_vc_ok_s) begin
            rd_addr_s = ADDR_W'(int'(out_vc) * BUFFER_DEPTH + int'(head_s[out_vc]));
            out_data  = mem_r[rd_addr_s];
        end else begin
            rd_addr_s = '0;
            out_data  = '0;
        end
    end

    // Shared storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (|wr_ok_s) begin
            mem_r[wr_addr_s] <= in_data;
        end
    end

    // One credit per accepted read, tagged with the VC that was dequeued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_r <= '0;
        end else begin
            credit_r.valid <= |rd_ok_s;
            if (|rd_ok_s) begin
                credit_r.vc <= CREDIT_VC_MAX_W'(out_vc);
            end
        end
    end

    logic credit_unused_s;
    assign credit_unused_s = ^credit_r.vc;
    assign credit_valid    = credit_r.valid;
    assign credit_vc       = credit_r.vc[VC_W-1:0];
    assign usedw           = count_s;

`ifdef VC_BUFFER_STATS_EN
    logic [NUM_VC-1:0][CNT_W-1:0] peak_r;

    // High-water mark compares against the next count so it moves on the same edge as usedw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_r <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (count_nxt_s[v] > peak_r[v]) begin
                    peak_r[v] <= count_nxt_s[v];
                end
            end
        end
    end

    assign peak_usedw = peak_r;

`ifndef SYNTHESIS
    logic [5:0] stat_cnt_r;

    // Periodic occupancy print for simulation runs only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt_r <= 6'd0;
        end else begin
            stat_cnt_r <= stat_cnt_r + 6'd1;
            if (stat_cnt_r == 6'd63) begin
                for (int v = 0; v < NUM_VC; v++) begin
                    $display("vc_buffer stats: vc %0d usedw %0d", v, count_s[v]);
                end
            end
        end
    end
`endif
`else
    logic stats_unused_s;
    assign stats_unused_s = ^count_nxt_s;
    assign peak_usedw     = '0;
`endif

endmodule

// File: tb/tb_vc_buffer.sv
// tb_vc_buffer: directed self-checking bench for vc_buffer with
// BUFFER_DEPTH=5, BUFFER_WIDTH=64, NUM_VC=2 (VC_W=1, CNT_W=3).
module tb_vc_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_vc;
    logic [63:0] in_data;
    logic        out_req;
    logic        out_vc;
    logic [63:0] out_data;
    logic [1:0]  empty;
    logic [1:0]  full;
    logic [5:0]  usedw;
    logic        credit_valid;
    logic        credit_vc;
    logic [1:0]  overflow;
    logic [5:0]  peak_usedw;

    int tests = 0;
    int fails = 0;

`ifdef VC_BUFFER_STATS_EN
    localparam logic [5:0] PEAK_FULL = 6'b101_101;
`else
    localparam logic [5:0] PEAK_FULL = 6'b000_000;
`endif

    vc_buffer #(
        .BUFFER_DEPTH (5),
        .BUFFER_WIDTH (64),
        .NUM_VC       (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_vc        (in_vc),
        .in_data      (in_data),
        .out_req      (out_req),
        .out_vc       (out_vc),
        .out_data     (out_data),
        .empty        (empty),
        .full         (full),
        .usedw        (usedw),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .overflow     (overflow),
        .peak_usedw   (peak_usedw)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic vc, input logic [63:0] data);
        in_valid = 1'b1;
        in_vc    = vc;
        in_data  = data;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic vc);
        out_req = 1'b1;
        out_vc  = vc;
        tick();
        out_req = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_vc    = 1'b0;
        in_data  = 64'h0;
        out_req  = 1'b0;
        out_vc   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset then idle
        check("rst_empty", 64'(empty), 64'h3);
        check("rst_full", 64'(full), 64'h0);
        check("rst_usedw", 64'(usedw), 64'h0);
        check("rst_credit", 64'(credit_valid), 64'h0);
        check("rst_credit_vc", 64'(credit_vc), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        check("rst_peak", 64'(peak_usedw), 64'h0);

        // Fill VC1, sixth write is dropped
        for (int i = 0; i < 5; i++) begin
            wr(1'b1, 64'hA0 + 64'(i));
        end
        check("vc1_full_before_ovf", 64'(full), 64'h2);
        check("vc1_ovf_clear", 64'(overflow), 64'h0);
        wr(1'b1, 64'hA5);
        check("vc1_full", 64'(full), 64'h2);
        check("vc1_usedw5", 64'(usedw), 64'h28);
        check("vc1_overflow", 64'(overflow), 64'h2);
        check("vc1_empty", 64'(empty), 64'h1);

        // Back-to-back reads drain VC1 in order with a credit each cycle
        out_vc  = 1'b1;
        out_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("vc1_rd_data", out_data, 64'hA0 + 64'(i));
            tick();
            check("vc1_credit", 64'(credit_valid), 64'h1);
            check("vc1_credit_vc", 64'(credit_vc), 64'h1);
            check("vc1_rd_usedw", 64'(usedw[5:3]), 64'(4 - i));
        end
        out_req = 1'b0;
        tick();
        check("vc1_credit_end", 64'(credit_valid), 64'h0);
        check("vc1_drained", 64'(empty), 64'h3);
        check("vc1_ovf_sticky", 64'(overflow), 64'h2);

        // Interleaved writes to both VCs
        wr(1'b0, 64'h10);
        wr(1'b1, 64'h20);
        wr(1'b0, 64'h11);
        out_vc = 1'b0;
        #1;
        check("il_vc0_head", out_data, 64'h10);
        out_vc = 1'b1;
        #1;
        check("il_vc1_head", out_data, 64'h20);
        check("il_usedw", 64'(usedw), 64'h0A);
        rd(1'b0);
        check("il_credit_vc0", 64'(credit_vc), 64'h0);
        out_vc = 1'b0;
        #1;
        check("il_vc0_next", out_data, 64'h11);
        rd(1'b0);
        rd(1'b1);
        check("il_credit_vc1", 64'(credit_vc), 64'h1);
        check("il_empty", 64'(empty), 64'h3);

        // Read of empty VC is ignored
        rd(1'b1);
        check("empty_rd_credit", 64'(credit_valid), 64'h0);
        check("empty_rd_usedw", 64'(usedw), 64'h0);

        // VC0 full with simultaneous read and write: only read accepted
        for (int i = 0; i < 5; i++) begin
            wr(1'b0, 64'h30 + 64'(i));
        end
        check("vc0_full", 64'(full), 64'h1);
        in_valid = 1'b1;
        in_vc    = 1'b0;
        in_data  = 64'h99;
        out_req  = 1'b1;
        out_vc   = 1'b0;
        tick();
        in_valid = 1'b0;
        out_req  = 1'b0;
        check("full_rw_usedw", 64'(usedw[2:0]), 64'h4);
        check("full_rw_overflow", 64'(overflow), 64'h3);
        check("full_rw_credit", 64'(credit_valid), 64'h1);
        check("full_rw_head", out_data, 64'h31);
        rd(1'b0);
        check("vc0_cnt3", 64'(usedw[2:0]), 64'h3);

        // Count 3 with simultaneous read and write: count holds
        in_valid = 1'b1;
        in_vc    = 1'b0;
        in_data  = 64'h99;
        out_req  = 1'b1;
        tick();
        in_valid = 1'b0;
        out_req  = 1'b0;
        check("mid_rw_usedw", 64'(usedw[2:0]), 64'h3);
        check("mid_rw_credit", 64'(credit_valid), 64'h1);
        check("mid_rw_d0", out_data, 64'h33);
        rd(1'b0);
        check("mid_rw_d1", out_data, 64'h34);
        rd(1'b0);
        check("mid_rw_d2", out_data, 64'h99);
        rd(1'b0);
        check("mid_rw_empty", 64'(empty), 64'h3);
        check("peak_after_full", 64'(peak_usedw), 64'(PEAK_FULL));

        // Wrap-around: 12 write/read pairs on VC0
        for (int i = 0; i < 12; i++) begin
            wr(1'b0, 64'h40 + 64'(i));
            check("wrap_usedw1", 64'(usedw[2:0]), 64'h1);
            check("wrap_data", out_data, 64'h40 + 64'(i));
            rd(1'b0);
            check("wrap_usedw0", 64'(usedw[2:0]), 64'h0);
            check("wrap_credit", 64'(credit_valid), 64'h1);
        end

        // Reset mid-operation with three flits in VC0 and a read pending
        wr(1'b0, 64'h50);
        wr(1'b0, 64'h51);
        wr(1'b0, 64'h52);
        check("pre_rst_usedw", 64'(usedw), 64'h03);
        check("pre_rst_peak", 64'(peak_usedw), 64'(PEAK_FULL));
        out_req = 1'b1;
        out_vc  = 1'b0;
        rst     = 1'b1;
        #2;
        check("async_rst_empty", 64'(empty), 64'h3);
        check("async_rst_usedw", 64'(usedw), 64'h0);
        check("async_rst_credit", 64'(credit_valid), 64'h0);
        tick();
        check("in_rst_credit", 64'(credit_valid), 64'h0);
        rst     = 1'b0;
        out_req = 1'b0;
        tick();
        check("post_rst_credit", 64'(credit_valid), 64'h0);
        check("post_rst_empty", 64'(empty), 64'h3);
        check("post_rst_overflow", 64'(overflow), 64'h0);
        check("post_rst_peak", 64'(peak_usedw), 64'h0);
        wr(1'b0, 64'h77);
        check("post_rst_write", out_data, 64'h77);
        check("post_rst_usedw", 64'(usedw), 64'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
